rx: RTL and testbench

Pulse-distance serial receiver for the single-wire audio link. It decodes frames from the matching transmitter into parallel WIDTH-bit samples. The frame format is sync burst, sync silence, then WIDTH data bits MSB first. Each data bit is a burst followed by a short (0) or long (1) silence, and the frame closes with a stop burst. The block sits at the receive end of the link and feeds the audio sample path.

---
 rtl/rx_if.sv | 32 +++
 rtl/rx.sv | 185 ++++++++++++++++++
 tb/tb_rx.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_if.sv
// Line-side bundle for the pulse-distance receiver.
// RX_ERR_COUNT_EN adds the err_count status field.
interface rx_if #(
  parameter int WIDTH = 8
);
  logic             signal_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             error_out;
  logic             busy;
`ifdef RX_ERR_COUNT_EN
  logic [7:0]       err_count;
`endif

  // Transmitter/environment side: drives the raw line, observes results.
  modport master (
    output signal_in,
`ifdef RX_ERR_COUNT_EN
    input  err_count,
`endif
    input  data_out, valid_out, error_out, busy
  );

  // Receiver side.
  modport slave (
    input  signal_in,
`ifdef RX_ERR_COUNT_EN
    output err_count,
`endif
    output data_out, valid_out, error_out, busy
  );
endinterface

// File: rtl/rx.sv
// Pulse-distance serial receiver: sync burst/silence, WIDTH data bits
// MSB first (burst + short/long silence), stop burst.
// Optional macro RX_ERR_COUNT_EN adds a saturating rejected-frame counter.
module rx #(
  parameter int SBD   = 700,
  parameter int SSD   = 700,
  parameter int BBD   = 400,
  parameter int BSD0  = 200,
  parameter int BSD1  = 400,
  parameter int TOL   = 50,
  parameter int WIDTH = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  rx_if.slave  bus
);
  localparam int BCW = $clog2(WIDTH + 1);

  localparam logic [15:0] SBD_LO  = 16'(SBD - TOL);
  localparam logic [15:0] SBD_HI  = 16'(SBD + TOL);
  localparam logic [15:0] SSD_LO  = 16'(SSD - TOL);
  localparam logic [15:0] SSD_HI  = 16'(SSD + TOL);
  localparam logic [15:0] BBD_LO  = 16'(BBD - TOL);
  localparam logic [15:0] BBD_HI  = 16'(BBD + TOL);
  localparam logic [15:0] BSD0_LO = 16'(BSD0 - TOL);
  localparam logic [15:0] BSD0_HI = 16'(BSD0 + TOL);
  localparam logic [15:0] BSD1_LO = 16'(BSD1 - TOL);
  localparam logic [15:0] BSD1_HI = 16'(BSD1 + TOL);

  typedef enum logic [2:0] {IDLE, SYNC_H, SYNC_L, BIT_H, BIT_L, STOP_H} state_t;

  state_t           state_q;
  logic             s1_q, s_q, sd_q;
  logic [15:0]      cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] data_q;
  logic [BCW-1:0]   bcnt_q;
  logic             valid_q, error_q;
  logic [1:0]       prime_q;
  logic             armed_q;
  logic             rise_w, fall_w;

  assign rise_w = s_q & ~sd_q;
  assign fall_w = ~s_q & sd_q;

  function automatic logic in_win(input logic [15:0] c, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      s1_q <= bus.signal_in;
      s_q  <= s1_q;
      sd_q <= s_q;
    end
  end

  // Saturating run-length counter; holds the finished run length on an edge cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= 16'd0;
    end else if (s_q == sd_q) begin
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= 16'd1;
    end
  end

  // Arm only after a genuine low has been seen, so a line already high at
  // reset release does not look like a sync burst.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prime_q <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
      if (prime_q == 2'd2 && !s_q) armed_q <= 1'b1;
    end
  end

  // Frame decoder with registered result pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_w && armed_q) state_q <= SYNC_H;
        end
        SYNC_H: begin
          // Anything not shaped like a sync burst is a glitch: drop quietly.
          if (fall_w) state_q <= in_win(cnt_q, SBD_LO, SBD_HI) ? SYNC_L : IDLE;
          else if (cnt_q > SBD_HI) state_q <= IDLE;
        end
        SYNC_L: begin
          if (rise_w) begin
            if (in_win(cnt_q, SSD_LO, SSD_HI)) begin
              state_q <= BIT_H;
              bcnt_q  <= '0;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b1;
            end
          end else if (cnt_q > SSD_HI) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end
        end
        BIT_H: begin
          if (fall_w) begin
            if (in_win(cnt_q, BBD_LO, BBD_HI)) begin
              state_q <= BIT_L;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b1;
            end
          end else if (cnt_q > BBD_HI) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end
        end
        BIT_L: begin
          if (rise_w) begin
            if (in_win(cnt_q, BSD0_LO, BSD0_HI) || in_win(cnt_q, BSD1_LO, BSD1_HI)) begin
              sr_q    <= {sr_q[WIDTH-2:0], in_win(cnt_q, BSD1_LO, BSD1_HI)};
              bcnt_q  <= bcnt_q + BCW'(1);
              state_q <= (bcnt_q == BCW'(WIDTH - 1)) ? STOP_H : BIT_H;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b1;
            end
          end else if (cnt_q > BSD1_HI) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end
        end
        STOP_H: begin
          if (fall_w) begin
            state_q <= IDLE;
            if (in_win(cnt_q, BBD_LO, BBD_HI)) begin
              data_q  <= sr_q;
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end else if (cnt_q > BBD_HI) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RX_ERR_COUNT_EN
  logic [7:0] errcnt_q;

  // Saturating count of rejected frames.
  always_ff @(posedge clk_in) begin
    if (rst_in) errcnt_q <= 8'd0;
    else if (error_q && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
  end

  assign bus.err_count = errcnt_q;
`endif

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;
  assign bus.busy      = (state_q != IDLE) && (state_q != SYNC_H);
endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: drives whole frames as lists of run lengths and
// compares decoded results against a run-length-rule reference model.
module tb_rx;
  localparam int W    = 8;
  localparam int SBD  = 700;
  localparam int SSD  = 700;
  localparam int BBD  = 400;
  localparam int BSD0 = 200;
  localparam int BSD1 = 400;
  localparam int TOL  = 50;
  localparam int NS   = 2 * W + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_if #(.WIDTH(W)) bus();
  rx #(.WIDTH(W)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] vq_data[$];
  int           vq_cyc[$];
  int           eq_cyc[$];
  int           both_cnt = 0;

  always @(negedge clk) begin
    if (bus.valid_out) begin
      vq_data.push_back(bus.data_out);
      vq_cyc.push_back(cyc);
    end
    if (bus.error_out) eq_cyc.push_back(cyc);
    if (bus.valid_out && bus.error_out) both_cnt <= both_cnt + 1;
  end

  int           dur[0:NS-1];
  int           nseg;
  int           edge_cyc[0:NS];
  logic         busy_mid;
  logic [W-1:0] exp_data;

  function automatic bit ok(input int v, input int nom);
    return (v >= nom - TOL) && (v <= nom + TOL);
  endfunction

  // Reference: walk the run lengths of a full frame using the window rules.
  function automatic void predict(output int kind, output logic [W-1:0] d);
    kind = 0;
    d    = '0;
    if (!ok(dur[0], SBD)) return;
    kind = 2;
    if (!ok(dur[1], SSD)) return;
    for (int b = 0; b < W; b++) begin
      if (!ok(dur[2 + 2 * b], BBD)) return;
      if (ok(dur[3 + 2 * b], BSD0)) d = {d[W-2:0], 1'b0};
      else if (ok(dur[3 + 2 * b], BSD1)) d = {d[W-2:0], 1'b1};
      else return;
    end
    if (!ok(dur[NS-1], BBD)) return;
    kind = 1;
  endfunction

  task automatic build(input logic [W-1:0] d, input int skew);
    dur[0] = SBD + skew;
    dur[1] = SSD + skew;
    for (int i = 0; i < W; i++) begin
      dur[2 + 2 * i] = BBD + skew;
      dur[3 + 2 * i] = (d[W-1-i] ? BSD1 : BSD0) + skew;
    end
    dur[NS-1] = BBD + skew;
    nseg = NS;
  endtask

  // Even segments are high, odd segments low; line returns low afterwards.
  task automatic drive(input int gap);
    for (int i = 0; i < nseg; i++) begin
      edge_cyc[i] = cyc;
      bus.signal_in = (i % 2 == 0);
      if (i == nseg - 1) busy_mid = bus.busy;
      repeat (dur[i]) @(negedge clk);
    end
    edge_cyc[nseg] = cyc;
    bus.signal_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_q();
    vq_data.delete();
    vq_cyc.delete();
    eq_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.signal_in = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.data_out); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
    checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.error_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    clear_q();
    rst = 1'b0;
    repeat (SBD) @(negedge clk);
    bus.signal_in = 1'b0;
    repeat (1500) @(negedge clk);
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL high_at_release_err: got %0d pulses expected 0", eq_cyc.size()); end
    checks++; if (vq_data.size() != 0) begin errors++; $display("FAIL high_at_release_valid: got %0d pulses expected 0", vq_data.size()); end
    exp_data = '0;
  endtask

  task automatic test_ideal();
    clear_q();
    build(8'hA5, 0);
    drive(20);
    checks++;
    if (vq_data.size() != 1) begin
      errors++; $display("FAIL ideal_count: got %0d valid expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'hA5) begin errors++; $display("FAIL ideal_data: got %h expected a5", vq_data[0]); end
      checks++; if (vq_cyc[0] != edge_cyc[nseg] + 3) begin errors++; $display("FAIL ideal_latency: got %0d expected %0d", vq_cyc[0] - edge_cyc[nseg], 3); end
    end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL ideal_err: got %0d pulses expected 0", eq_cyc.size()); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL ideal_busy_mid: got %b expected 1", busy_mid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ideal_busy_after: got %b expected 0", bus.busy); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL ideal_hold: got %h expected a5", bus.data_out); end
    exp_data = 8'hA5;
  endtask

  task automatic test_back_to_back();
    clear_q();
    build(8'h00, 0);
    drive(1);
    build(8'hFF, 0);
    drive(20);
    checks++;
    if (vq_data.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d valid expected 2", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", vq_data[0]); end
      checks++; if (vq_data[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", vq_data[1]); end
    end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL b2b_err: got %0d pulses expected 0", eq_cyc.size()); end
    exp_data = 8'hFF;
  endtask

  task automatic test_skew();
    clear_q();
    build(8'h3C, 40);
    drive(20);
    build(8'h3C, -40);
    drive(20);
    checks++;
    if (vq_data.size() != 2) begin
      errors++; $display("FAIL skew_count: got %0d valid expected 2", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'h3C) begin errors++; $display("FAIL skew_plus: got %h expected 3c", vq_data[0]); end
      checks++; if (vq_data[1] !== 8'h3C) begin errors++; $display("FAIL skew_minus: got %h expected 3c", vq_data[1]); end
    end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL skew_err: got %0d pulses expected 0", eq_cyc.size()); end
    exp_data = 8'h3C;
  endtask

  task automatic test_bad_bit();
    clear_q();
    build(8'h96, 0);
    dur[7] = 300;
    nseg = 9;
    drive(20);
    checks++;
    if (eq_cyc.size() != 1) begin
      errors++; $display("FAIL bad_err_count: got %0d pulses expected 1", eq_cyc.size());
    end else begin
      checks++; if (eq_cyc[0] != edge_cyc[8] + 3) begin errors++; $display("FAIL bad_err_time: got %0d expected %0d", eq_cyc[0], edge_cyc[8] + 3); end
    end
    checks++; if (vq_data.size() != 0) begin errors++; $display("FAIL bad_valid: got %0d pulses expected 0", vq_data.size()); end
    checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL bad_hold: got %h expected %h", bus.data_out, exp_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_glitch();
    clear_q();
    bus.signal_in = 1'b1;
    repeat (300) @(negedge clk);
    bus.signal_in = 1'b0;
    repeat (100) @(negedge clk);
    build(8'h5A, 0);
    drive(20);
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL glitch_err: got %0d pulses expected 0", eq_cyc.size()); end
    checks++;
    if (vq_data.size() != 1) begin
      errors++; $display("FAIL glitch_count: got %0d valid expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'h5A) begin errors++; $display("FAIL glitch_data: got %h expected 5a", vq_data[0]); end
    end
    exp_data = 8'h5A;
  endtask

  task automatic test_reset_mid();
    clear_q();
    build(8'hFF, 0);
    nseg = 5;
    drive(150);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL rmid_err: got %0d pulses expected 0", eq_cyc.size()); end
    checks++; if (vq_data.size() != 0) begin errors++; $display("FAIL rmid_valid: got %0d pulses expected 0", vq_data.size()); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", bus.data_out); end
    build(8'h81, 0);
    drive(20);
    checks++;
    if (vq_data.size() != 1) begin
      errors++; $display("FAIL rmid_count: got %0d valid expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'h81) begin errors++; $display("FAIL rmid_frame: got %h expected 81", vq_data[0]); end
    end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL rmid_err2: got %0d pulses expected 0", eq_cyc.size()); end
    exp_data = 8'h81;
  endtask

  task automatic test_random();
    int           kind;
    logic [W-1:0] d, pd;
    int           idx;
    for (int f = 0; f < 2; f++) begin
      clear_q();
      d = W'($urandom);
      build(d, 0);
      for (int i = 0; i < NS; i++) dur[i] = dur[i] + int'($urandom_range(0, 80)) - 40;
      if ($urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, NS - 1));
        dur[idx] = int'($urandom_range(20, 900));
      end
      predict(kind, pd);
      $display("random frame %0d: data %h predicted kind %0d", f, d, kind);
      drive(20);
      checks++; if (vq_data.size() != ((kind == 1) ? 1 : 0)) begin errors++; $display("FAIL rand_valid: got %0d pulses expected %0d", vq_data.size(), (kind == 1) ? 1 : 0); end
      checks++; if (eq_cyc.size() != ((kind == 2) ? 1 : 0)) begin errors++; $display("FAIL rand_err: got %0d pulses expected %0d", eq_cyc.size(), (kind == 2) ? 1 : 0); end
      if (kind == 1) exp_data = pd;
      checks++; if (bus.data_out !== exp_data) begin errors++; $display("FAIL rand_data: got %h expected %h", bus.data_out, exp_data); end
    end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL both_pulses: got %0d cycles expected 0", both_cnt); end
  endtask

`ifdef RX_ERR_COUNT_EN
  task automatic test_err_count();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL errcnt_reset: got %0d expected 0", bus.err_count); end
    clear_q();
    for (int k = 0; k < 3; k++) begin
      dur[0] = SBD;
      dur[1] = 300;
      dur[2] = BBD;
      nseg = 3;
      drive(20);
    end
    checks++; if (eq_cyc.size() != 3) begin errors++; $display("FAIL errcnt_pulses: got %0d expected 3", eq_cyc.size()); end
    checks++; if (bus.err_count !== 8'd3) begin errors++; $display("FAIL errcnt_value: got %0d expected 3", bus.err_count); end
  endtask
`endif

  initial begin
    bus.signal_in = 1'b0;
    exp_data = '0;
    busy_mid = 1'b0;
    nseg = NS;
    @(negedge clk);
    test_reset();
    test_ideal();
    test_back_to_back();
    test_skew();
    test_bad_bit();
    test_glitch();
    test_reset_mid();
    test_random();
`ifdef RX_ERR_COUNT_EN
    test_err_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
